tea_iter_core: RTL
==================

TEA_ITER_CORE -- requirements
Module: tea_iter_core

Interface
REQ-001 SHALL have parameter DELTA, default 32'h9E3779B9, round constant.
REQ-002 SHALL have parameter ROUNDS, default 32, number of Feistel cycles; range 1..64.
REQ-003 SHALL have parameter UNROLL, default 1, rounds applied per clock; ROUNDS mod UNROLL != 0 SHALL be an elaboration error.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, core can accept a request.
REQ-008 SHALL have port decrypt, input, 1, 0 = encrypt, 1 = decrypt; sampled with the request.
REQ-009 SHALL have port data_in, input, 64, block; [63:32] = v0, [31:0] = v1.
REQ-010 SHALL have port key, input, 128, k0 = [127:96], k1 = [95:64], k2 = [63:32], k3 = [31:0].
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port data_out, output, 64, result; same v0/v1 packing as data_in.
REQ-014 SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-016 IDLE: in_valid & in_ready at an edge SHALL latch v0, v1, key, decrypt and sum_init, clear the round counter, and go to RUN.
REQ-017 sum_init SHALL be DELTA for encrypt, and (DELTA*ROUNDS) mod 2^32 for decrypt (0xC6EF3720 at defaults).
REQ-018 Encrypt round SHALL do, in order: v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1); then v1 += ((v0'<<4)+k2) ^ (v0'+sum) ^ ((v0'>>5)+k3); then sum += DELTA.
REQ-019 Decrypt round SHALL do, in order: v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3); then v0 -= ((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1); then sum -= DELTA.
REQ-020 All arithmetic SHALL be unsigned 32-bit modulo 2^32; shifts SHALL be logical; no carry SHALL be kept.
REQ-021 Each RUN edge SHALL apply UNROLL chained rounds and increment the counter; after N = ROUNDS/UNROLL edges the FSM SHALL go to DONE.
REQ-022 out_valid SHALL be 1 exactly in DONE, first N cycles after the accepting edge (32 at defaults).
REQ-023 data_out SHALL be driven from registered v0/v1 and SHALL hold stable while out_valid & !out_ready.
REQ-024 DONE & out_ready SHALL return the FSM to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-025 in_valid, data_in, key and decrypt SHALL be ignored outside IDLE; changing them mid-run SHALL NOT affect the result.
REQ-026 The round counter SHALL be $clog2(N+1) bits wide and SHALL NOT wrap during RUN.

Reset
REQ-027 rst_n low at an edge SHALL force IDLE, clear v0, v1, sum, counter and latched key/mode to 0, and abandon any operation in progress without producing output.
REQ-028 During and after reset, outputs SHALL be in_ready = 1, out_valid = 0, busy = 0, data_out = 0.

Structure
REQ-029 Package tea_pkg SHALL hold the DELTA default, the FSM state encoding and the key/word slice constants.
REQ-030 Sub-module tea_round SHALL be a combinational single round (inputs v0, v1, sum, key, decrypt; outputs v0, v1, sum), instantiated UNROLL times in a chain.

Verification
REQ-031 Encrypt, key = 0, data_in = 0 -> data_out = 64'h41EA3A0A_94BAA940, with out_valid 32 cycles after accept.
REQ-032 Decrypt, key = 0, data_in = 64'h41EA3A0A_94BAA940 -> data_out = 0.
REQ-033 out_ready held low 5 cycles in DONE -> out_valid and data_out stable, in_ready = 0, and an in_valid pulse is ignored.
REQ-034 rst_n low at round 10 -> the next cycle shows in_ready = 1, out_valid = 0 and data_out = 0; no stale result appears afterwards.
REQ-035 UNROLL = 4 -> same vector as REQ-031, with out_valid 8 cycles after accept.
REQ-036 200 random key/block pairs, encrypt then decrypt, back-to-back -> original block recovered each time, and results match the software model.

Source files
------------

// File: rtl/tea_pkg.sv
// Shared constants for the iterative TEA core: round constant default,
// FSM state encoding, key/word slice positions and the TEA mixing function.
package tea_pkg;

    localparam logic [31:0] DELTA_DEFAULT = 32'h9E3779B9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int WORD_W = 32;
    localparam int K0_LSB = 96;
    localparam int K1_LSB = 64;
    localparam int K2_LSB = 32;
    localparam int K3_LSB = 0;
    localparam int V0_LSB = 32;
    localparam int V1_LSB = 0;

    // F(v) = ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb), all mod 2^32
    function automatic logic [31:0] tea_mix(
        input logic [31:0] v,
        input logic [31:0] s,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_round.sv
// One combinational TEA Feistel cycle, encrypt or decrypt.
// Ports: v0_i/v1_i/sum_i/key_i/decrypt_i in; v0_o/v1_o/sum_o out.
module tea_round
    import tea_pkg::*;
#(
    parameter logic [31:0] DELTA = DELTA_DEFAULT
) (
    input  logic [31:0]  v0_i,
    input  logic [31:0]  v1_i,
    input  logic [31:0]  sum_i,
    input  logic [127:0] key_i,
    input  logic         decrypt_i,
    output logic [31:0]  v0_o,
    output logic [31:0]  v1_o,
    output logic [31:0]  sum_o
);

    logic [31:0] k0, k1, k2, k3;

    assign k0 = key_i[K0_LSB +: WORD_W];
    assign k1 = key_i[K1_LSB +: WORD_W];
    assign k2 = key_i[K2_LSB +: WORD_W];
    assign k3 = key_i[K3_LSB +: WORD_W];

    // Second half-round consumes the freshly updated word.
    always_comb begin
        v0_o  = v0_i;
        v1_o  = v1_i;
        sum_o = sum_i;
        if (!decrypt_i) begin
            v0_o  = v0_i + tea_mix(v1_i, sum_i, k0, k1);
            v1_o  = v1_i + tea_mix(v0_o, sum_i, k2, k3);
            sum_o = sum_i + DELTA;
        end else begin
            v1_o  = v1_i - tea_mix(v0_i, sum_i, k2, k3);
            v0_o  = v0_i - tea_mix(v1_o, sum_i, k0, k1);
            sum_o = sum_i - DELTA;
        end
    end

endmodule

// File: rtl/tea_iter_core.sv
// Iterative TEA block cipher core, UNROLL rounds per clock.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/decrypt/data_in/key
// request side, out_valid/out_ready/data_out result side, busy status.
module tea_iter_core
    import tea_pkg::*;
#(
    parameter logic [31:0] DELTA  = DELTA_DEFAULT,
    parameter int          ROUNDS = 32,
    parameter int          UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         decrypt,
    input  logic [63:0]  data_in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out,
    output logic         busy
);

    generate
        if (ROUNDS < 1 || ROUNDS > 64 || UNROLL < 1 ||
            (ROUNDS % UNROLL) != 0) begin : g_bad_cfg
            $error("tea_iter_core: illegal ROUNDS/UNROLL combination");
        end
    endgenerate

    localparam int N  = ROUNDS / UNROLL;
    localparam int CW = $clog2(N + 1);

    // Decrypt starts from the sum reached after the last encrypt round.
    localparam logic [31:0] SUM_DEC = DELTA * 32'(ROUNDS);

    logic [1:0]    state_q, state_d;
    logic [31:0]   v0_q, v0_d;
    logic [31:0]   v1_q, v1_d;
    logic [31:0]   sum_q, sum_d;
    logic [127:0]  key_q, key_d;
    logic          dec_q, dec_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] c_v0  [UNROLL+1];
    logic [31:0] c_v1  [UNROLL+1];
    logic [31:0] c_sum [UNROLL+1];

    assign c_v0[0]  = v0_q;
    assign c_v1[0]  = v1_q;
    assign c_sum[0] = sum_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        tea_round #(.DELTA(DELTA)) u_round (
            .v0_i      (c_v0[i]),
            .v1_i      (c_v1[i]),
            .sum_i     (c_sum[i]),
            .key_i     (key_q),
            .decrypt_i (dec_q),
            .v0_o      (c_v0[i+1]),
            .v1_o      (c_v1[i+1]),
            .sum_o     (c_sum[i+1])
        );
    end

    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        sum_d   = sum_q;
        key_d   = key_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    v0_d    = data_in[V0_LSB +: WORD_W];
                    v1_d    = data_in[V1_LSB +: WORD_W];
                    key_d   = key;
                    dec_d   = decrypt;
                    sum_d   = decrypt ? SUM_DEC : DELTA;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                v0_d  = c_v0[UNROLL];
                v1_d  = c_v1[UNROLL];
                sum_d = c_sum[UNROLL];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            key_q   <= '0;
            dec_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign data_out  = {v0_q, v1_q};

endmodule
